// File: rtl/bsg_link_pkg.sv
// Shared definitions for the BSG source-synchronous link: word geometry and
// the beat/lane to byte mapping used by both ends of the link.
package bsg_link_pkg;

    localparam int unsigned WORD_W         = 64;
    localparam int unsigned LANE_W         = 8;
    localparam int unsigned BEATS_PER_WORD = 4;
    localparam int unsigned CNT_W          = 7;
    localparam int unsigned BEAT_W         = $clog2(BEATS_PER_WORD);
    localparam int unsigned BYTE_IDX_W     = $clog2(WORD_W / LANE_W);

    // Byte index 4*beat[1] + 2*lane + beat[0], written as a bit concatenation.
    function automatic logic [BYTE_IDX_W-1:0] lane_byte(input logic [BEAT_W-1:0] beat,
                                                        input logic              lane);
        return {beat[1], lane, beat[0]};
    endfunction

endpackage

// File: rtl/bsg_link_fifo.sv
// 1-write/1-read register-array FIFO; a write while full is accepted only
// when a read happens in the same cycle.
module bsg_link_fifo #(
    parameter int unsigned ELS   = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enq_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             deq_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int unsigned AW    = $clog2(ELS);
    localparam int unsigned PTR_W = AW + 1;

    logic [WIDTH-1:0] mem_q [ELS];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic             empty;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    end

    always_comb begin
        rd_en  = deq_i && !empty;
        wr_en  = enq_i && (!full || rd_en);
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < ELS; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wptr_q[AW-1:0]] <= data_i;
            end
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_comb begin
        data_o  = mem_q[rptr_q[AW-1:0]];
        valid_o = !empty;
        full_o  = full;
    end

endmodule

// File: rtl/bsg_downstream_in.sv
// Receive endpoint of the BSG link: assembles 2-byte beats into 64-bit words,
// buffers them for the core and returns one credit token per consumed word.
module bsg_downstream_in
    import bsg_link_pkg::*;
#(
    parameter int unsigned FIFO_ELS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              io_valid_in,
    input  logic [LANE_W-1:0] io_data_in_ch0,
    input  logic [LANE_W-1:0] io_data_in_ch1,
    output logic              io_token_out,
    output logic              core_valid_out,
    output logic [WORD_W-1:0] core_data_out,
    input  logic              core_yumi_in,
    output logic [CNT_W-1:0]  recv_cnt,
    output logic              overflow
);

    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;
    logic              token_q, token_d;
    logic              overflow_q, overflow_d;

    logic              enq;
    logic              deq;
    logic              fifo_valid;
    logic              fifo_full;
    logic [WORD_W-1:0] fifo_data;

    // asm_d carries the current beat merged in, so beat 3 enqueues asm_d directly.
    always_comb begin
        asm_d      = asm_q;
        beat_d     = beat_q;
        recv_cnt_d = recv_cnt_q;
        if (io_valid_in) begin
            asm_d[{lane_byte(beat_q, 1'b0), 3'b000} +: LANE_W] = io_data_in_ch0;
            asm_d[{lane_byte(beat_q, 1'b1), 3'b000} +: LANE_W] = io_data_in_ch1;
            beat_d     = beat_q + BEAT_W'(1);
            recv_cnt_d = recv_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        enq        = io_valid_in && (beat_q == BEAT_W'(BEATS_PER_WORD - 1));
        deq        = core_yumi_in && fifo_valid;
        token_d    = deq;
        overflow_d = overflow_q || (enq && fifo_full && !deq);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            beat_q     <= '0;
            asm_q      <= '0;
            recv_cnt_q <= '0;
            token_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            beat_q     <= beat_d;
            asm_q      <= asm_d;
            recv_cnt_q <= recv_cnt_d;
            token_q    <= token_d;
            overflow_q <= overflow_d;
        end
    end

    bsg_link_fifo #(
        .ELS   (FIFO_ELS),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_n_i (rst),
        .enq_i   (enq),
        .data_i  (asm_d),
        .deq_i   (deq),
        .data_o  (fifo_data),
        .valid_o (fifo_valid),
        .full_o  (fifo_full)
    );

    always_comb begin
        io_token_out   = token_q;
        core_valid_out = fifo_valid;
        core_data_out  = fifo_data;
        recv_cnt       = recv_cnt_q;
        overflow       = overflow_q;
    end

endmodule

// File: doc/bsg_downstream_in.md
# bsg_downstream_in

Receive-side endpoint of the BSG source-synchronous link, sitting directly downstream of the upstream output stage. It captures 2-byte beats from two 8-bit channels and reassembles every four beats into one 64-bit core word. Completed words are buffered in a small FIFO and offered to the core over valid/yumi. A one-cycle token is returned upstream for every word the core consumes, which replenishes the upstream credit count.

## Interface
- `FIFO_ELS`, 4: buffered 64-bit words; power of two, minimum 2; upstream initial credit equals this value.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-low reset (asserted when 0).
- `io_valid_in` input 1: beat valid from link.
- `io_data_in_ch0` input 8: lane 0 byte.
- `io_data_in_ch1` input 8: lane 1 byte.
- `io_token_out` output 1: credit return, one-cycle pulse per consumed word.
- `core_valid_out` output 1: FIFO head holds a word.
- `core_data_out` output 64: FIFO head word.
- `core_yumi_in` input 1: core consumes head this cycle; only meaningful when `core_valid_out`=1.
- `recv_cnt` output 7: beats received, wraps modulo 128.
- `overflow` output 1: sticky; a word completed while the FIFO was full with no dequeue.

## Operation
- Beat counter `beat[1:0]` selects byte lanes. With `c = beat[1]` and `s = beat[0]`, `ch0` writes word byte `4c+s` and `ch1` writes byte `4c+2+s`.
- Resulting beat order: beat0 = bytes 0,2; beat1 = bytes 1,3; beat2 = bytes 4,6; beat3 = bytes 5,7.
- On a beat (`io_valid_in`=1):
  - write both lanes into the assembly register;
  - increment `beat`, wrapping 3→0;
  - increment `recv_cnt`.
- On beat 3 the complete word (assembly register merged with the current beat) is enqueued at that same edge.
- Enqueue with FIFO full:
  - with `core_yumi_in`=1 in the same cycle, it is accepted and occupancy is unchanged;
  - otherwise the word is dropped and `overflow` is set to 1, where it stays until reset.
- Dequeue happens when `core_yumi_in`=1 and `core_valid_out`=1. The read pointer advances, and `io_token_out`=1 in the next cycle for exactly one cycle.
- `core_yumi_in`=1 while `core_valid_out`=0 is ignored: no pointer move, no token.
- `io_valid_in`=0 holds `beat` and the assembly register; gaps between beats are legal.
- Reset values (`rst`=0 at an edge):
  - `beat`=0, FIFO empty, `core_valid_out`=0, `core_data_out`=0;
  - `io_token_out`=0, `recv_cnt`=0, `overflow`=0.
- Reset mid-word discards the partial word; the next beat is treated as beat0.
- Inputs during reset are ignored.

## Timing
- Beat sampled at the rising edge; no combinational path from `io_*` inputs to any output.
- Word latency: the edge that captures beat3 is followed by `core_valid_out`=1 with the word on `core_data_out` in the next cycle, when the FIFO was empty.
- `core_data_out` and `core_valid_out` are driven from registered FIFO state only.
- Token latency: yumi in cycle N → `io_token_out` high in cycle N+1.
- Back-to-back yumis give back-to-back token pulses.
- Sustained throughput: one word per 4 beat-cycles. Simultaneous enqueue and dequeue is supported every cycle.
- Pointers are `$clog2(FIFO_ELS)`+1 bits wide:
  - full = MSBs differ and the remaining bits are equal;
  - empty = all bits equal.

## Structure
- Shared package `bsg_link_pkg`:
  - `WORD_W`=64, `LANE_W`=8, `BEATS_PER_WORD`=4, `CNT_W`=7;
  - lane-to-byte mapping function `lane_byte(beat, lane)`.
- The upstream output stage uses the same package so that byte order is defined in one place.
- Sub-module `bsg_link_fifo`: 1-write/1-read register-array FIFO providing full/empty, with same-cycle enqueue-when-full allowed under dequeue.
- Top level contains the beat counter, assembly register, token register, `recv_cnt` and the overflow flag.

## Test plan
- **Single word:** after reset, 4 consecutive beats (ch0,ch1) = (0x11,0x33), (0x22,0x44), (0x55,0x77), (0x66,0x88). Expect `core_valid_out`=1 one cycle after beat3, `core_data_out`=0x8877665544332211, and `recv_cnt`=4.
- **Gapped beats:** the same beats with 3 idle cycles between each give an identical word. No early `core_valid_out`.
- **Fill and drain, `FIFO_ELS`=4:**
  - send 4 words with `core_yumi_in`=0; FIFO is full and `overflow`=0;
  - a 5th word completes → `overflow`=1 and the FIFO contents are unchanged;
  - drain with yumi held high → 4 words in order and 4 consecutive `io_token_out` pulses, each one cycle after its yumi.
- **Full with simultaneous dequeue:** FIFO full; beat3 of a new word coincides with yumi. The head is consumed, the new word is enqueued at the tail, occupancy stays 4, and `overflow` stays 0.
- **Reset mid-word and invalid yumi:**
  - after 2 beats, pull `rst` low for 1 cycle, then send 4 fresh beats; the output word contains only the fresh bytes and `recv_cnt`=4;
  - yumi asserted while the FIFO is empty produces no token.
